// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, legal parameter ranges and parity helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;

    localparam int SAMPLE_CNT_W = $clog2(OVERSAMPLE_MAX);
    localparam int BIT_CNT_W    = $clog2(DATA_BITS_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
        , PARITY = 3'd4
`endif
    } rx_state_e;

    // Nonzero XOR is an error for even parity, zero XOR is an error for odd parity.
    function automatic logic parity_error(input logic [DATA_BITS_MAX-1:0] data,
                                          input logic parity_bit,
                                          input logic odd);
        return (^data) ^ parity_bit ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle pulse every CLK_DIV clocks.
// Shared between the UART receiver and transmitter.
module baud_tick_gen #(
    parameter int CLK_DIV = 163
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with valid/ready output and overrun detection.
// Define UART_RX_PARITY_EN to build the parity bit check; otherwise o_parity_err is tied low.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 163,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_tick
);

    import uart_pkg::*;

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS out of range");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_param: OVERSAMPLE must be even and in range");
    end
    if (CLK_DIV < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_misc
        $error("uart_rx_param: CLK_DIV or PARITY_ODD illegal");
    end

    localparam logic [SAMPLE_CNT_W-1:0] MID_CNT   = SAMPLE_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_CNT_W-1:0] BIT_END   = SAMPLE_CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0]    LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]    LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    logic tick;
    logic rxMeta_q, rxSync_q, rxPrev_q;
    logic rxFall;

    rx_state_e                 state_q, state_d;
    logic [SAMPLE_CNT_W-1:0]   sampleCnt_q, sampleCnt_d;
    logic [BIT_CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0]      shift_q, shift_d;
    logic                      frameErr_q, frameErr_d;
    logic                      loadWord;

    logic [DATA_BITS-1:0]      outData_q;
    logic                      outValid_q;
    logic                      outFrameErr_q;
    logic                      overrun_q;

`ifdef UART_RX_PARITY_EN
    logic                      parityErr_q, parityErr_d;
    logic                      outParityErr_q;
`endif

    baud_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .o_tick(tick)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    assign rxFall = rxPrev_q & ~rxSync_q;

    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        frameErr_d  = frameErr_q;
        loadWord    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityErr_d = parityErr_q;
`endif
        case (state_q)
            IDLE: begin
                if (rxFall) begin
                    state_d     = START;
                    sampleCnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sampleCnt_q == MID_CNT) begin
                        if (!rxSync_q) begin
                            state_d     = DATA;
                            sampleCnt_d = '0;
                            bitCnt_d    = '0;
                            frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                            parityErr_d = 1'b0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sampleCnt_q == BIT_END) begin
                        sampleCnt_d = '0;
                        shift_d     = {rxSync_q, shift_q[DATA_BITS-1:1]};
                        if (bitCnt_q == LAST_DATA) begin
                            bitCnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d  = PARITY;
`else
                            state_d  = STOP;
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sampleCnt_q == BIT_END) begin
                        sampleCnt_d = '0;
                        parityErr_d = parity_error(DATA_BITS_MAX'(shift_q), rxSync_q, PARITY_ODD[0]);
                        state_d     = STOP;
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                // Leaving at the last mid-bit sample lets a start edge half a bit later be caught.
                if (tick) begin
                    if (sampleCnt_q == BIT_END) begin
                        sampleCnt_d = '0;
                        if (!rxSync_q) begin
                            frameErr_d = 1'b1;
                        end
                        if (bitCnt_q == LAST_STOP) begin
                            bitCnt_d = '0;
                            state_d  = IDLE;
                            loadWord = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= parityErr_d;
`endif
        end
    end

    // A word loads when the holding register is free or being accepted; otherwise it is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            outData_q      <= '0;
            outValid_q     <= 1'b0;
            outFrameErr_q  <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            outParityErr_q <= 1'b0;
`endif
        end else begin
            overrun_q <= loadWord & outValid_q & ~i_ready;
            if (loadWord && (!outValid_q || i_ready)) begin
                outData_q      <= shift_q;
                outFrameErr_q  <= frameErr_d;
                outValid_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                outParityErr_q <= parityErr_q;
`endif
            end else if (outValid_q && i_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign o_data      = outData_q;
    assign o_valid     = outValid_q;
    assign o_frame_err = outFrameErr_q;
    assign o_overrun   = overrun_q;
    assign o_tick      = tick;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = outParityErr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized bench for uart_rx_param against a frame-level reference model.
// Parity checks are built only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int OVERSAMPLE = 16;
    localparam int CLK_DIV    = 2;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = OVERSAMPLE * CLK_DIV;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 i_rx = 1'b1;
    logic                 i_ready = 1'b0;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_overrun;
    logic                 o_tick;

    int checks = 0;
    int errors = 0;
    int overruns = 0;
    int tickCount = 0;
    int doubleTick = 0;
    logic tickPrev = 1'b0;
    logic [9:0] gotQ[$];

    always #5 clock = ~clock;

    uart_rx_param #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .CLK_DIV   (CLK_DIV),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_overrun   (o_overrun),
        .o_tick      (o_tick)
    );

    // Monitor on the falling edge: records accepted words, overrun pulses and tick spacing.
    always @(negedge clock) begin
        if (reset && o_valid && i_ready) gotQ.push_back({o_parity_err, o_frame_err, o_data});
        if (reset && o_overrun) overruns++;
        if (o_tick) tickCount++;
        if (o_tick && tickPrev) doubleTick++;
        tickPrev = o_tick;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int parityBitFor(input logic [7:0] d, input logic flip);
        return ((($countones(d) + PARITY_ODD) % 2) ^ int'(flip));
    endfunction

    // Reference model: what one received frame should deliver as {parity_err, frame_err, data}.
    function automatic logic [9:0] expectWord(input logic [7:0] d, input logic stopBit, input logic flip);
        logic ferr;
        logic perr;
        ferr = (stopBit == 1'b0);
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = ((($countones(d) + parityBitFor(d, flip)) % 2) != PARITY_ODD);
`else
        if (flip) perr = 1'b0;
`endif
        return {perr, ferr, d};
    endfunction

    task automatic sendBit(input logic b);
        i_rx = b;
        cycles(BIT_CLKS);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic flip);
        sendBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
        sendBit(parityBitFor(d, flip) != 0);
`endif
        for (int i = 0; i < STOP_BITS; i++) sendBit(stopBit);
        i_rx = 1'b1;
    endtask

    task automatic waitWord(input string tag, output logic [9:0] w);
        int budget;
        budget = 4 * BIT_CLKS;
        while (gotQ.size() == 0 && budget > 0) begin
            cycles(1);
            budget--;
        end
        checkOutput({tag, " arrived"}, 32'(gotQ.size() > 0), 32'd1);
        if (gotQ.size() > 0) w = gotQ.pop_front();
        else w = 'x;
    endtask

    initial begin
        logic [9:0] w;
        logic [7:0] d;
        logic stopBit, flip, readyNow;
        int ov0;

        // Reset state
        reset = 1'b0;
        cycles(5);
        checkOutput("reset o_valid", o_valid, 0);
        checkOutput("reset o_data", o_data, 0);
        checkOutput("reset o_frame_err", o_frame_err, 0);
        checkOutput("reset o_parity_err", o_parity_err, 0);
        checkOutput("reset o_overrun", o_overrun, 0);
        checkOutput("reset o_tick", o_tick, 0);
        reset = 1'b1;
        cycles(4);

        // Tick rate and width
        tickCount = 0;
        doubleTick = 0;
        cycles(40);
        checkOutput("tick count", tickCount, 40 / CLK_DIV);
        checkOutput("tick width", doubleTick, 0);

        // Basic 0x03 frame with consumer ready
        i_ready = 1'b1;
        applyStimulus(8'h03, 1'b1, 1'b0);
        waitWord("basic", w);
        checkOutput("basic word", w, expectWord(8'h03, 1'b1, 1'b0));
        cycles(2);
        checkOutput("basic valid pulse", o_valid, 0);
        checkOutput("basic single word", gotQ.size(), 0);

        // Glitch of four ticks is rejected
        cycles(BIT_CLKS);
        i_rx = 1'b0;
        cycles(4 * CLK_DIV);
        i_rx = 1'b1;
        cycles(3 * BIT_CLKS);
        checkOutput("glitch no word", gotQ.size(), 0);
        checkOutput("glitch o_valid", o_valid, 0);
        d = 8'($urandom);
        applyStimulus(d, 1'b1, 1'b0);
        waitWord("after glitch", w);
        checkOutput("after glitch word", w, expectWord(d, 1'b1, 1'b0));

        // Framing error then recovery
        cycles(BIT_CLKS);
        applyStimulus(8'h55, 1'b0, 1'b0);
        waitWord("frame err", w);
        checkOutput("frame err word", w, expectWord(8'h55, 1'b0, 1'b0));
        cycles(BIT_CLKS);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        waitWord("frame ok", w);
        checkOutput("frame ok word", w, expectWord(8'hAA, 1'b1, 1'b0));

`ifdef UART_RX_PARITY_EN
        // Parity good and bad
        cycles(BIT_CLKS);
        applyStimulus(8'h03, 1'b1, 1'b0);
        waitWord("parity good", w);
        checkOutput("parity good flag", w[9], 0);
        cycles(BIT_CLKS);
        applyStimulus(8'h03, 1'b1, 1'b1);
        waitWord("parity bad", w);
        checkOutput("parity bad flag", w[9], 1);
        checkOutput("parity bad data", w[7:0], 8'h03);
`endif

        // Back-to-back frames with consumer stalled: two overruns, first word kept
        cycles(BIT_CLKS);
        i_ready = 1'b0;
        ov0 = overruns;
        applyStimulus(8'h03, 1'b1, 1'b0);
        applyStimulus(8'h03, 1'b1, 1'b0);
        applyStimulus(8'h20, 1'b1, 1'b0);
        cycles(BIT_CLKS);
        checkOutput("overrun count", overruns - ov0, 2);
        checkOutput("overrun held valid", o_valid, 1);
        checkOutput("overrun held data", o_data, 8'h03);
        checkOutput("overrun no accept", gotQ.size(), 0);
        i_ready = 1'b1;
        waitWord("overrun accept", w);
        checkOutput("overrun accept word", w, expectWord(8'h03, 1'b1, 1'b0));
        cycles(2);
        checkOutput("overrun valid cleared", o_valid, 0);

        // Randomized frames, random stop-bit corruption and consumer readiness
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            stopBit = ($urandom_range(0, 3) != 0);
            flip = 1'($urandom_range(0, 1));
            readyNow = 1'($urandom_range(0, 1));
            i_ready = readyNow;
            cycles(BIT_CLKS);
            applyStimulus(d, stopBit, flip);
            if (!readyNow) begin
                cycles(BIT_CLKS / 2);
                checkOutput("rand held valid", o_valid, 1);
                checkOutput("rand held data", o_data, d);
                checkOutput("rand held frame_err", o_frame_err, expectWord(d, stopBit, flip) >> 8 & 1);
                i_ready = 1'b1;
            end
            waitWord("rand", w);
            checkOutput("rand word", w, expectWord(d, stopBit, flip));
        end

        // Reset in the middle of data bit 3, then a clean 0x20 frame
        i_ready = 1'b1;
        cycles(BIT_CLKS);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        i_rx = 1'b1;
        cycles(BIT_CLKS / 2);
        reset = 1'b0;
        cycles(4);
        checkOutput("midreset o_data", o_data, 0);
        checkOutput("midreset o_valid", o_valid, 0);
        checkOutput("midreset o_frame_err", o_frame_err, 0);
        checkOutput("midreset o_parity_err", o_parity_err, 0);
        checkOutput("midreset o_overrun", o_overrun, 0);
        reset = 1'b1;
        cycles(3 * BIT_CLKS);
        checkOutput("midreset no word", gotQ.size(), 0);
        checkOutput("midreset idle valid", o_valid, 0);
        applyStimulus(8'h20, 1'b1, 1'b0);
        waitWord("post reset", w);
        checkOutput("post reset word", w, expectWord(8'h20, 1'b1, 1'b0));

        cycles(BIT_CLKS);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
